// File: rtl/llc_mshr_table_pkg.sv
// rtl/llc_mshr_table_pkg.sv - shared types and constants for the LLC MSHR table
package llc_mshr_table_pkg;

   localparam int LLC_N_MSHR       = 4;
   localparam int LLC_MSHR_BITS    = $clog2(LLC_N_MSHR);
   localparam int LLC_MSHR_BITS_P1 = LLC_MSHR_BITS + 1;

   typedef logic [7:0]               llc_set_t;
   typedef logic [11:0]              llc_tag_t;
   typedef logic [2:0]               llc_way_t;
   typedef logic [LLC_MSHR_BITS-1:0] llc_mshr_id_t;

   typedef struct packed {
      logic     valid;
      llc_set_t set;
      llc_tag_t tag;
      llc_way_t way;
   } llc_mshr_entry_t;

endpackage

// File: rtl/llc_mshr_pri_enc.sv
// rtl/llc_mshr_pri_enc.sv - lowest-index priority encoder
module llc_mshr_pri_enc #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         any,
   output logic [W-1:0] id
);

   // scan from the top down so the lowest set bit wins
   always_comb begin
      any = |req;
      id  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) id = W'(i);
      end
   end

endmodule

// File: rtl/llc_mshr_table.sv
// rtl/llc_mshr_table.sv - MSHR table with lookup, count pulses and set-conflict tracking
module llc_mshr_table
   import llc_mshr_table_pkg::*;
#(
   parameter int N_MSHR   = LLC_N_MSHR,
   parameter int SET_BITS = $bits(llc_set_t),
   parameter int TAG_BITS = $bits(llc_tag_t),
   parameter int WAY_BITS = $bits(llc_way_t),
   localparam int ID_W    = $clog2(N_MSHR),
   localparam int CNT_W   = $clog2(N_MSHR) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic [SET_BITS-1:0] alloc_set,
   input  logic [TAG_BITS-1:0] alloc_tag,
   input  logic [WAY_BITS-1:0] alloc_way,
   output logic [ID_W-1:0]     alloc_id,
   input  logic                free_valid,
   input  logic [ID_W-1:0]     free_id,
   input  logic                lookup_valid,
   input  logic [SET_BITS-1:0] lookup_set,
   input  logic [TAG_BITS-1:0] lookup_tag,
   output logic                lookup_done,
   output logic                lookup_hit,
   output logic [ID_W-1:0]     lookup_hit_id,
   output logic                lookup_conflict,
   output logic                add_mshr_entry,
   output logic                incr_mshr_cnt,
   output logic                set_set_conflict,
   output logic                clr_set_conflict,
   output logic [CNT_W-1:0]    free_cnt,
   output logic                free_err
);

   logic [N_MSHR-1:0]   valid_q;
   logic [SET_BITS-1:0] set_q [N_MSHR];
   logic [TAG_BITS-1:0] tag_q [N_MSHR];
   logic [WAY_BITS-1:0] way_q [N_MSHR];

   logic                cfl_active;
   logic [SET_BITS-1:0] cfl_set;
   logic                cfl_pend;
   logic [SET_BITS-1:0] cfl_pend_set;

   logic [N_MSHR-1:0]   hit_vec;
   logic [N_MSHR-1:0]   set_vec;
   logic                hit_any;
   logic [ID_W-1:0]     hit_id;
   logic                alloc_fire;
   logic                free_fire;
   logic                conflict_now;
   logic                cfl_remain;
   logic                clr_now;
   logic                unused_way;

   llc_mshr_pri_enc #(.N(N_MSHR)) u_free_enc (
      .req (~valid_q),
      .any (alloc_ready),
      .id  (alloc_id)
   );

   llc_mshr_pri_enc #(.N(N_MSHR)) u_hit_enc (
      .req (hit_vec),
      .any (hit_any),
      .id  (hit_id)
   );

   // compare the probe key against the pre-update table
   always_comb begin
      hit_vec = '0;
      set_vec = '0;
      for (int i = 0; i < N_MSHR; i++) begin
         set_vec[i] = valid_q[i] && (set_q[i] == lookup_set);
         hit_vec[i] = valid_q[i] && (set_q[i] == lookup_set) && (tag_q[i] == lookup_tag);
      end
   end

   // request qualification and the post-update check for the tracked conflict set
   always_comb begin
      alloc_fire   = alloc_valid && alloc_ready;
      free_fire    = free_valid && valid_q[free_id];
      conflict_now = lookup_valid && (|set_vec) && !hit_any;
      cfl_remain   = 1'b0;
      for (int i = 0; i < N_MSHR; i++) begin
         if (valid_q[i] && !(free_fire && (free_id == ID_W'(i))) && (set_q[i] == cfl_set))
            cfl_remain = 1'b1;
         if (alloc_fire && (alloc_id == ID_W'(i)) && (alloc_set == cfl_set))
            cfl_remain = 1'b1;
      end
      clr_now = cfl_active && free_fire && (set_q[free_id] == cfl_set) && !cfl_remain;
   end

   // way is carried for the entry but not consumed inside this block
   always_comb begin
      unused_way = 1'b0;
      for (int i = 0; i < N_MSHR; i++) unused_way = unused_way ^ (^way_q[i]);
   end

   // entry payload needs no reset; the valid bit qualifies it
   always_ff @(posedge clk) begin
      if (rst && alloc_fire) begin
         set_q[alloc_id] <= alloc_set;
         tag_q[alloc_id] <= alloc_tag;
         way_q[alloc_id] <= alloc_way;
      end
   end

   // valid bits, free count, result registers and conflict tracking
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q          <= '0;
         free_cnt         <= CNT_W'(N_MSHR);
         free_err         <= 1'b0;
         add_mshr_entry   <= 1'b0;
         incr_mshr_cnt    <= 1'b0;
         lookup_done      <= 1'b0;
         lookup_hit       <= 1'b0;
         lookup_hit_id    <= '0;
         lookup_conflict  <= 1'b0;
         set_set_conflict <= 1'b0;
         clr_set_conflict <= 1'b0;
         cfl_active       <= 1'b0;
         cfl_set          <= '0;
         cfl_pend         <= 1'b0;
         cfl_pend_set     <= '0;
      end else begin
         if (alloc_fire) valid_q[alloc_id] <= 1'b1;
         if (free_fire)  valid_q[free_id]  <= 1'b0;
         if (free_valid && !valid_q[free_id]) free_err <= 1'b1;

         if (alloc_fire && !free_fire)      free_cnt <= free_cnt - CNT_W'(1);
         else if (free_fire && !alloc_fire) free_cnt <= free_cnt + CNT_W'(1);

         // a simultaneous alloc and free cancel out, so neither pulse fires
         add_mshr_entry <= alloc_fire && !free_fire;
         incr_mshr_cnt  <= free_fire && !alloc_fire;

         lookup_done     <= lookup_valid;
         lookup_hit      <= lookup_valid && hit_any;
         lookup_hit_id   <= lookup_valid ? hit_id : '0;
         lookup_conflict <= conflict_now;

         set_set_conflict <= 1'b0;
         clr_set_conflict <= 1'b0;
         if (cfl_pend) begin
            set_set_conflict <= 1'b1;
            cfl_active       <= 1'b1;
            cfl_set          <= cfl_pend_set;
            cfl_pend         <= 1'b0;
         end else if (clr_now) begin
            // clear goes out first; a coincident conflict is raised next cycle
            clr_set_conflict <= 1'b1;
            cfl_active       <= 1'b0;
            if (conflict_now) begin
               cfl_pend     <= 1'b1;
               cfl_pend_set <= lookup_set;
            end
         end else if (conflict_now && !cfl_active) begin
            set_set_conflict <= 1'b1;
            cfl_active       <= 1'b1;
            cfl_set          <= lookup_set;
         end
      end
   end

endmodule

// File: tb/tb_llc_mshr_table.sv
// tb/tb_llc_mshr_table.sv - self-checking bench with a behavioural MSHR model
module tb_llc_mshr_table;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic [7:0]  alloc_set = '0;
   logic [11:0] alloc_tag = '0;
   logic [2:0]  alloc_way = '0;
   logic [1:0]  alloc_id;
   logic        free_valid = 1'b0;
   logic [1:0]  free_id = '0;
   logic        lookup_valid = 1'b0;
   logic [7:0]  lookup_set = '0;
   logic [11:0] lookup_tag = '0;
   logic        lookup_done;
   logic        lookup_hit;
   logic [1:0]  lookup_hit_id;
   logic        lookup_conflict;
   logic        add_mshr_entry;
   logic        incr_mshr_cnt;
   logic        set_set_conflict;
   logic        clr_set_conflict;
   logic [2:0]  free_cnt;
   logic        free_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   llc_mshr_table dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_valid      (alloc_valid),
      .alloc_ready      (alloc_ready),
      .alloc_set        (alloc_set),
      .alloc_tag        (alloc_tag),
      .alloc_way        (alloc_way),
      .alloc_id         (alloc_id),
      .free_valid       (free_valid),
      .free_id          (free_id),
      .lookup_valid     (lookup_valid),
      .lookup_set       (lookup_set),
      .lookup_tag       (lookup_tag),
      .lookup_done      (lookup_done),
      .lookup_hit       (lookup_hit),
      .lookup_hit_id    (lookup_hit_id),
      .lookup_conflict  (lookup_conflict),
      .add_mshr_entry   (add_mshr_entry),
      .incr_mshr_cnt    (incr_mshr_cnt),
      .set_set_conflict (set_set_conflict),
      .clr_set_conflict (clr_set_conflict),
      .free_cnt         (free_cnt),
      .free_err         (free_err)
   );

   always #5 clk = ~clk;

   // behavioural model state
   bit m_valid [N];
   int m_set [N];
   int m_tag [N];
   bit m_err;
   bit e_done, e_hit, e_cfl, e_add, e_incr, e_setc, e_clrc;
   int e_hid;
   bit m_cfl_active, m_pend;
   int m_cfl_set, m_pend_set;

   function automatic int m_free_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (!m_valid[i]) c++;
      return c;
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // model advances on every rising edge from the same inputs the DUT sees
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
         m_err = 0; e_done = 0; e_hit = 0; e_cfl = 0; e_add = 0; e_incr = 0;
         e_setc = 0; e_clrc = 0; e_hid = 0;
         m_cfl_active = 0; m_pend = 0; m_cfl_set = 0; m_pend_set = 0;
      end else begin
         int  aid, hid, freed_set;
         bit  afire, ffire, hit, setm, remain, clr_now, new_cfl;
         aid   = m_lowest_free();
         afire = alloc_valid && (aid >= 0);
         ffire = free_valid && m_valid[free_id];
         if (free_valid && !m_valid[free_id]) m_err = 1;

         hit = 0; setm = 0; hid = 0;
         for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_set[i] == int'(lookup_set)) begin
               setm = 1;
               if (m_tag[i] == int'(lookup_tag) && !hit) begin hit = 1; hid = i; end
            end
         end
         e_done  = lookup_valid;
         e_hit   = lookup_valid && hit;
         e_hid   = (lookup_valid && hit) ? hid : 0;
         new_cfl = lookup_valid && setm && !hit;
         e_cfl   = new_cfl;
         e_add   = afire && !ffire;
         e_incr  = ffire && !afire;

         freed_set = m_set[free_id];
         if (ffire) m_valid[free_id] = 0;
         if (afire) begin
            m_valid[aid] = 1; m_set[aid] = int'(alloc_set); m_tag[aid] = int'(alloc_tag);
         end

         remain = 0;
         for (int i = 0; i < N; i++) if (m_valid[i] && m_set[i] == m_cfl_set) remain = 1;
         clr_now = m_cfl_active && ffire && (freed_set == m_cfl_set) && !remain;

         e_setc = 0; e_clrc = 0;
         if (m_pend) begin
            e_setc = 1; m_cfl_active = 1; m_cfl_set = m_pend_set; m_pend = 0;
         end else if (clr_now) begin
            e_clrc = 1; m_cfl_active = 0;
            if (new_cfl) begin m_pend = 1; m_pend_set = int'(lookup_set); end
         end else if (new_cfl && !m_cfl_active) begin
            e_setc = 1; m_cfl_active = 1; m_cfl_set = int'(lookup_set);
         end
      end
   end

   // every-cycle comparison on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("alloc_ready", alloc_ready, m_free_count() != 0);
         if (m_free_count() != 0) check("alloc_id", alloc_id, m_lowest_free());
         check("free_cnt", free_cnt, m_free_count());
         check("free_err", free_err, m_err);
         check("lookup_done", lookup_done, e_done);
         check("lookup_hit", lookup_hit, e_hit);
         check("lookup_hit_id", lookup_hit_id, e_hid);
         check("lookup_conflict", lookup_conflict, e_cfl);
         check("add_mshr_entry", add_mshr_entry, e_add);
         check("incr_mshr_cnt", incr_mshr_cnt, e_incr);
         check("set_set_conflict", set_set_conflict, e_setc);
         check("clr_set_conflict", clr_set_conflict, e_clrc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 0; free_valid = 0; lookup_valid = 0;
   endtask

   task automatic do_alloc(input int s, input int t);
      alloc_valid = 1; alloc_set = 8'(s); alloc_tag = 12'(t); alloc_way = 3'(t);
   endtask

   task automatic do_free(input int id);
      free_valid = 1; free_id = 2'(id);
   endtask

   task automatic do_probe(input int s, input int t);
      lookup_valid = 1; lookup_set = 8'(s); lookup_tag = 12'(t);
   endtask

   initial begin
      rst = 0; idle();
      step(); step();
      rst = 1; cmp_en = 1;
      check("rst_free_cnt", free_cnt, 4);
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_alloc_id", alloc_id, 0);
      check("rst_free_err", free_err, 0);
      check("rst_lookup_done", lookup_done, 0);

      // fill the table: ids 0..3 in order
      for (int k = 0; k < 4; k++) begin
         check("fill_alloc_id", alloc_id, k);
         do_alloc((k == 0) ? 5 : k, (k == 0) ? 3 : k + 8);
         step();
         check("fill_add", add_mshr_entry, 1);
         check("fill_free_cnt", free_cnt, 3 - k);
      end
      idle();
      check("full_ready", alloc_ready, 0);

      do_probe(5, 7); step(); idle();
      check("cfl_done", lookup_done, 1);
      check("cfl_conflict", lookup_conflict, 1);
      check("cfl_hit", lookup_hit, 0);
      check("cfl_set_pulse", set_set_conflict, 1);

      do_probe(5, 3); step(); idle();
      check("hit_flag", lookup_hit, 1);
      check("hit_id", lookup_hit_id, 0);
      check("hit_no_cfl", lookup_conflict, 0);
      check("hit_no_set_pulse", set_set_conflict, 0);

      do_probe(9, 'hABC); step(); idle();
      check("miss_done", lookup_done, 1);
      check("miss_hit", lookup_hit, 0);
      check("miss_cfl", lookup_conflict, 0);

      // full table: free 2 and try to allocate in the same cycle
      do_free(2); do_alloc(2, 'h20); step(); idle();
      check("full_free_incr", incr_mshr_cnt, 1);
      check("full_free_add", add_mshr_entry, 0);
      check("full_free_cnt", free_cnt, 1);
      check("full_free_alloc_id", alloc_id, 2);
      do_alloc(2, 'h20); step(); idle();
      check("realloc_add", add_mshr_entry, 1);
      check("realloc_cnt", free_cnt, 0);

      do_free(0); step(); idle();
      check("clr_pulse", clr_set_conflict, 1);
      check("clr_incr", incr_mshr_cnt, 1);

      do_free(0); step(); idle();
      check("bad_free_err", free_err, 1);
      check("bad_free_incr", incr_mshr_cnt, 0);
      check("bad_free_cnt", free_cnt, 1);

      // reset mid-stream with requests present
      rst = 0; do_alloc(1, 1); do_probe(1, 1); step(); idle(); rst = 1;
      check("mid_rst_cnt", free_cnt, 4);
      check("mid_rst_err", free_err, 0);
      check("mid_rst_add", add_mshr_entry, 0);
      check("mid_rst_done", lookup_done, 0);

      do_alloc(1, 1); step(); do_alloc(1, 2); step(); idle();
      check("two_cnt", free_cnt, 2);
      check("simul_alloc_id", alloc_id, 2);
      do_free(1); do_alloc(3, 3); step(); idle();
      check("simul_add", add_mshr_entry, 0);
      check("simul_incr", incr_mshr_cnt, 0);
      check("simul_cnt", free_cnt, 2);
      check("simul_next_id", alloc_id, 1);

      do_free(3); step(); idle();
      check("free3_err", free_err, 1);
      check("free3_cnt", free_cnt, 2);
      check("free3_incr", incr_mshr_cnt, 0);

      // randomized traffic with a narrow key space to provoke hits and conflicts
      for (int c = 0; c < 3000; c++) begin
         rst          = ($urandom_range(0, 199) != 0);
         alloc_valid  = ($urandom_range(0, 1) == 1);
         alloc_set    = 8'($urandom_range(0, 3));
         alloc_tag    = 12'($urandom_range(0, 3));
         alloc_way    = 3'($urandom_range(0, 7));
         free_valid   = ($urandom_range(0, 9) < 4);
         free_id      = 2'($urandom_range(0, 3));
         lookup_valid = ($urandom_range(0, 2) != 0);
         lookup_set   = 8'($urandom_range(0, 3));
         lookup_tag   = 12'($urandom_range(0, 3));
         step();
      end
      rst = 1; idle(); step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
